uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// UART transmitter. A byte is accepted through a valid/busy handshake and
// sent as one start bit, the data bits LSB-first, an optional parity bit and
// one stop bit. Bit timing comes from an internal clocks-per-bit counter.
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit between the
// data bits and the stop bit. When it is defined, par_typ selects even (0) or
// odd (1) parity. When it is not defined, the parity state is compiled out
// and par_typ is ignored.
//
// tx_out and busy both come straight from flops. Their next values are
// derived from the next state, so the line only moves on bit boundaries.

module uart_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CYC_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CYC_W-1:0]      cyc_cnt;
  logic [CYC_W-1:0]      cyc_nxt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_nxt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  tx_nxt;
  logic                  busy_nxt;
  logic                  bit_done;

`ifdef UART_TX_PARITY_EN
  logic                  par_bit;
  logic                  par_nxt;
`else
  logic                  unused_par_typ;
  assign unused_par_typ = par_typ;
`endif

  assign bit_done = (cyc_cnt == CYC_LAST);

  // State register plus counters, shift register and the registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cyc_cnt   <= cyc_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      tx_out    <= tx_nxt;
      busy      <= busy_nxt;
`ifdef UART_TX_PARITY_EN
      par_bit   <= par_nxt;
`endif
    end
  end

  // Next-state logic: accept in IDLE, then step through the frame one bit period at a time
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_bit;
`endif
    case (state)
      IDLE: begin
        cyc_nxt = '0;
        bit_nxt = '0;
        if (data_valid) begin
          state_nxt = START;
          shift_nxt = p_data;
`ifdef UART_TX_PARITY_EN
          par_nxt   = (^p_data) ^ par_typ;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cyc_nxt   = '0;
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, taken from the state being entered
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Scoreboard bench for uart_tx_serializer at DATA_WIDTH=8, CLKS_PER_BIT=4.
// Every accepted byte is pushed as an expected frame. A line monitor
// reassembles each frame, one sample per cycle, and compares it with the
// front of the queue.
// Build with or without UART_TX_PARITY_EN, matching the build of the RTL.

module tb_uart_tx_serializer;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = DW + 3;
`else
  localparam int NB  = DW + 2;
`endif
  localparam int FRAME_CYC = NB * CPB;

  typedef struct {
    logic [7:0] data;
    logic       pt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int   n_checks = 0;
  int   n_fail = 0;
  int   frames_pushed = 0;
  int   frames_seen = 0;
  int   frames_aborted = 0;
  bit   mon_busy = 1'b0;
  exp_t exp_q[$];

  logic [CPB-1:0] per [NB];

  uart_tx_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .p_data(p_data),
    .data_valid(data_valid),
    .par_typ(par_typ),
    .tx_out(tx_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  function automatic logic [NB-1:0] expFrame(input exp_t e);
    logic [NB-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = e.data[i];
`ifdef UART_TX_PARITY_EN
    f[DW+1] = (^e.data) ^ e.pt;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic pt, input bit hold);
    @(negedge clk);
    p_data     = d;
    par_typ    = pt;
    data_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back('{d, pt});
    frames_pushed++;
    #1;
    if (!hold) data_valid = 1'b0;
    checkOutput($sformatf("accept_%02h", d), 32'({busy, tx_out}), 32'b10);
  endtask

  task automatic waitIdle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (!busy && !mon_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  // Line monitor: reassemble each frame from per-cycle samples and score it
  initial begin
    int            busy_cnt;
    bit            aborted;
    exp_t          e;
    logic [NB-1:0] f;
    forever begin
      @(negedge clk);
      if (!rst && tx_out === 1'b0) begin
        mon_busy = 1'b1;
        aborted  = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          per[i/CPB][i%CPB] = tx_out;
          if (busy === 1'b1) busy_cnt++;
        end
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (aborted) begin
            frames_aborted++;
          end else begin
            frames_seen++;
            f = expFrame(e);
            for (int b = 0; b < NB; b++)
              checkOutput($sformatf("frame%0d_%02h_bit%0d", frames_seen, e.data, b),
                          32'(per[b]), 32'({CPB{f[b]}}));
            checkOutput($sformatf("frame%0d_busy_cycles", frames_seen), 32'(busy_cnt), 32'(FRAME_CYC));
            @(negedge clk);
            if (!rst)
              checkOutput($sformatf("frame%0d_idle_after", frames_seen), 32'({busy, tx_out}), 32'b01);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    bit ok;
    rst        = 1'b1;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_typ    = 1'b0;
    @(negedge clk);
    checkOutput("reset_tx", 32'(tx_out), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] 0xA5 even parity");
    applyStimulus(8'hA5, 1'b0, 1'b0);
    waitIdle(200);

    $display("[TB] 0x00 and 0xFF odd parity");
    applyStimulus(8'h00, 1'b1, 1'b0);
    waitIdle(200);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    waitIdle(200);

    $display("[TB] data_valid pulse during a frame is ignored");
    applyStimulus(8'hA5, 1'b0, 1'b0);
    repeat (3*CPB + 2) @(negedge clk);
    p_data     = 8'h3C;
    par_typ    = 1'b1;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    waitIdle(200);
    repeat (3*CPB) @(negedge clk);
    checkOutput("no_second_frame", 32'({busy, tx_out}), 32'b01);

    $display("[TB] back-to-back frames with data_valid held");
    applyStimulus(8'h55, 1'b0, 1'b1);
    p_data = 8'hF0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("b2b_first_done", 32'(ok), 32'd1);
    checkOutput("b2b_idle_gap", 32'({busy, tx_out}), 32'b01);
    @(posedge clk);
    exp_q.push_back('{8'hF0, 1'b0});
    frames_pushed++;
    #1;
    data_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_restart", 32'({busy, tx_out}), 32'b10);
    waitIdle(200);

    $display("[TB] asynchronous reset in data bit 3");
    applyStimulus(8'hA5, 1'b0, 1'b0);
    repeat (4*CPB + 2) @(negedge clk);
    checkOutput("pre_rst_line", 32'({busy, tx_out}), 32'b10);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 32'({busy, tx_out}), 32'b01);
    repeat (2) @(negedge clk);
    checkOutput("rst_held", 32'({busy, tx_out}), 32'b01);
    rst = 1'b0;
    waitIdle(50);
    applyStimulus(8'h81, 1'b0, 1'b0);
    waitIdle(200);

    checkOutput("frames_aborted", 32'(frames_aborted), 32'd1);
    checkOutput("frames_completed", 32'(frames_seen), 32'(frames_pushed - frames_aborted));
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
